// File: rtl/indicator_pulse_driver.sv
// rtl/indicator_pulse_driver.sv - turns 1-cycle event pulses into timed blink/beep patterns
// One-deep pending slot; extra requests while the slot is full are dropped.
module indicator_pulse_driver #(
  parameter int CLK_FREQUENCY = 40_000_000,
  parameter int ON_HZ         = 4,
  parameter int OFF_HZ        = 4,
  parameter int GAP_HZ        = 1,
  parameter int COUNT_WIDTH   = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic [3:0] count_in,
  output logic       out_signal,
  output logic       busy,
  output logic       pending,
  output logic       dropped
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] OFF  = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  localparam logic [COUNT_WIDTH-1:0] ON_LAST  = COUNT_WIDTH'(CLK_FREQUENCY / ON_HZ - 1);
  localparam logic [COUNT_WIDTH-1:0] OFF_LAST = COUNT_WIDTH'(CLK_FREQUENCY / OFF_HZ - 1);
  localparam logic [COUNT_WIDTH-1:0] GAP_LAST = COUNT_WIDTH'(CLK_FREQUENCY / GAP_HZ - 1);

  logic [1:0]             state;
  logic [COUNT_WIDTH-1:0] counter;
  logic [3:0]             remaining;
  logic [3:0]             pending_count;
  logic                   valid;
  logic                   gap_done;

  assign valid    = trigger && (count_in != 4'd0);
  assign gap_done = (state == GAP) && (counter >= GAP_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      counter       <= '0;
      remaining     <= 4'd0;
      pending_count <= 4'd0;
      out_signal    <= 1'b0;
      busy          <= 1'b0;
      pending       <= 1'b0;
      dropped       <= 1'b0;
    end else begin
      dropped <= 1'b0;

      case (state)
        IDLE: begin
          if (valid) begin
            state      <= ON;
            remaining  <= count_in;
            counter    <= '0;
            out_signal <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ON: begin
          if (counter >= ON_LAST) begin
            state      <= OFF;
            counter    <= '0;
            out_signal <= 1'b0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        OFF: begin
          if (counter >= OFF_LAST) begin
            counter <= '0;
            if (remaining > 4'd1) begin
              remaining  <= remaining - 4'd1;
              state      <= ON;
              out_signal <= 1'b1;
            end else begin
              state <= GAP;
            end
          end else begin
            counter <= counter + 1'b1;
          end
        end
        GAP: begin
          if (gap_done) begin
            counter <= '0;
            if (pending) begin
              remaining  <= pending_count;
              state      <= ON;
              out_signal <= 1'b1;
            end else if (valid) begin
              remaining  <= count_in;
              state      <= ON;
              out_signal <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          counter    <= '0;
          out_signal <= 1'b0;
          busy       <= 1'b0;
        end
      endcase

      // On the final gap cycle the queued request starts and a new one takes its slot.
      if (valid && state != IDLE) begin
        if (gap_done) begin
          if (pending) pending_count <= count_in;
        end else if (!pending) begin
          pending       <= 1'b1;
          pending_count <= count_in;
        end else begin
          dropped <= 1'b1;
        end
      end else if (gap_done && pending) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_indicator_pulse_driver.sv
// tb/tb_indicator_pulse_driver.sv - bench for indicator_pulse_driver
// Timeline model (pattern start cycle + count + pending slot) checked every cycle.
module tb_indicator_pulse_driver;

  localparam int CLK_FREQUENCY = 100;
  localparam int ON_HZ  = 25;
  localparam int OFF_HZ = 50;
  localparam int GAP_HZ = 20;
  localparam int ON_C   = CLK_FREQUENCY / ON_HZ;
  localparam int OFF_C  = CLK_FREQUENCY / OFF_HZ;
  localparam int GAP_C  = CLK_FREQUENCY / GAP_HZ;
  localparam int PER    = ON_C + OFF_C;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       trigger = 1'b0;
  logic [3:0] count_in = 4'd0;
  logic       out_signal, busy, pending, dropped;

  int total = 0;
  int bad = 0;

  indicator_pulse_driver #(
    .CLK_FREQUENCY(CLK_FREQUENCY),
    .ON_HZ(ON_HZ),
    .OFF_HZ(OFF_HZ),
    .GAP_HZ(GAP_HZ),
    .COUNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .trigger(trigger),
    .count_in(count_in),
    .out_signal(out_signal),
    .busy(busy),
    .pending(pending),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  // Model: a pattern of n blinks starting in cycle st is busy for n*PER+GAP cycles.
  int  k = 0;
  int  st = 0;
  int  n = 0;
  int  pcnt = 0;
  bit  active = 0;
  bit  pend = 0;
  bit  drop = 0;

  always @(posedge clk) begin
    bit v;
    int e;
    bit exp_out;
    v = trigger && (count_in != 4'd0);
    drop = 0;
    if (!reset) begin
      active = 0;
      pend = 0;
    end else if (active && (k - st) == n * PER + GAP_C - 1) begin
      if (pend) begin
        st = k + 1;
        n = pcnt;
        pend = v;
        if (v) pcnt = int'(count_in);
      end else if (v) begin
        st = k + 1;
        n = int'(count_in);
      end else begin
        active = 0;
      end
    end else if (!active) begin
      if (v) begin
        active = 1;
        st = k + 1;
        n = int'(count_in);
      end
    end else if (v) begin
      if (!pend) begin
        pend = 1;
        pcnt = int'(count_in);
      end else begin
        drop = 1;
      end
    end
    k++;
    #1;
    e = k - st;
    exp_out = active && (e < n * PER) && ((e % PER) < ON_C);
    total++;
    if (out_signal !== exp_out || busy !== active || pending !== pend || dropped !== drop) begin
      bad++;
      $display("FAIL model cycle %0d: got out=%b busy=%b pend=%b drop=%b, want out=%b busy=%b pend=%b drop=%b",
               k, out_signal, busy, pending, dropped, exp_out, active, pend, drop);
    end
  end

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic run_until_idle(output int highs, output int busy_c);
    int g;
    highs = 0;
    busy_c = 0;
    g = 0;
    while (busy && g < 400) begin
      if (out_signal) highs++;
      busy_c++;
      g++;
      step(1);
    end
    chk("idle_timeout", g < 400 ? 1 : 0, 1);
  endtask

  task automatic one_blink_literal(input string tag);
    @(negedge clk);
    trigger = 1'b1; count_in = 4'd1;
    step(1);
    trigger = 1'b0;
    chk({tag, "_c1_out"}, int'(out_signal), 1);
    chk({tag, "_c1_busy"}, int'(busy), 1);
    step(3);
    chk({tag, "_c4_out"}, int'(out_signal), 1);
    step(1);
    chk({tag, "_c5_out"}, int'(out_signal), 0);
    chk({tag, "_c5_busy"}, int'(busy), 1);
    step(6);
    chk({tag, "_c11_busy"}, int'(busy), 1);
    step(1);
    chk({tag, "_c12_busy"}, int'(busy), 0);
  endtask

  initial begin
    int h, b;
    step(3);
    chk("rst_out", int'(out_signal), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending", int'(pending), 0);
    reset = 1'b1;
    step(2);

    one_blink_literal("single");
    step(2);

    // Three blinks
    trigger = 1'b1; count_in = 4'd3;
    step(1);
    trigger = 1'b0;
    run_until_idle(h, b);
    chk("three_highs", h, 12);
    chk("three_busy", b, 23);
    step(2);

    // Zero-count requests are ignored, idle and busy
    trigger = 1'b1; count_in = 4'd0;
    step(1);
    chk("zero_idle_busy", int'(busy), 0);
    trigger = 1'b1; count_in = 4'd1;
    step(1);
    trigger = 1'b1; count_in = 4'd0;
    step(1);
    trigger = 1'b0;
    chk("zero_busy_pend", int'(pending), 0);
    chk("zero_busy_drop", int'(dropped), 0);
    run_until_idle(h, b);
    step(2);

    // Pend during ON, drop during OFF
    trigger = 1'b1; count_in = 4'd2;
    step(1);
    trigger = 1'b1; count_in = 4'd1;
    step(1);
    trigger = 1'b0;
    chk("pend_set", int'(pending), 1);
    step(3);
    trigger = 1'b1; count_in = 4'd5;
    step(1);
    trigger = 1'b0;
    chk("drop_pulse", int'(dropped), 1);
    chk("drop_keeps_pend", int'(pending), 1);
    step(1);
    chk("drop_one_cycle", int'(dropped), 0);
    run_until_idle(h, b);
    chk("pend_highs", h, 8);
    chk("pend_busy", b, 22);
    step(2);

    // Valid request on last gap cycle while pending is full
    trigger = 1'b1; count_in = 4'd1;
    step(1);
    trigger = 1'b1; count_in = 4'd3;
    step(1);
    trigger = 1'b0;
    step(9);
    trigger = 1'b1; count_in = 4'd2;
    step(1);
    trigger = 1'b0;
    chk("gapedge_out", int'(out_signal), 1);
    chk("gapedge_pend", int'(pending), 1);
    chk("gapedge_drop", int'(dropped), 0);
    run_until_idle(h, b);
    chk("gapedge_highs", h, 20);
    chk("gapedge_busy", b, 40);
    step(2);

    // Async reset during second ON of a 3-blink pattern
    trigger = 1'b1; count_in = 4'd3;
    step(1);
    trigger = 1'b1; count_in = 4'd2;
    step(1);
    trigger = 1'b0;
    step(6);
    #2 reset = 1'b0;
    #1;
    chk("arst_out", int'(out_signal), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_pend", int'(pending), 0);
    step(2);
    reset = 1'b1;
    step(1);
    one_blink_literal("after_rst");

    // Random traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      trigger  = ($urandom_range(0, 9) == 0);
      count_in = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    trigger = 1'b0;
    step(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
